// File: rtl/save_stream.sv
// save_stream: executes one save instruction by reading a run of words from
// the output feature buffer and streaming them, with backpressure, to the
// AXI4 write master. Completion is reported on ap_done.
module save_stream #(
  parameter int unsigned SAVE_INST_LENGTH    = 96,
  parameter int unsigned C_M_AXI_ADDR_WIDTH  = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH  = 512,
  parameter int unsigned C_XFER_SIZE_WIDTH   = 32,
  parameter int unsigned BUF_ADDR_WIDTH      = 11
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
  output logic                          buf_rd_en,
  output logic [BUF_ADDR_WIDTH-1:0]     buf_rd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] buf_rd_data,
  output logic                          wr_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  wr_size,
  input  logic                          wr_done,
  output logic                          data_tvalid,
  input  logic                          data_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
  output logic                          data_tlast
);

  localparam int unsigned BW         = BUF_ADDR_WIDTH;
  localparam int unsigned DW         = C_M_AXI_DATA_WIDTH;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned FIELD_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Instruction field decode
  logic [BW-1:0]      inst_buf_start;
  logic [BW-1:0]      inst_beats;
  logic [FIELD_W-1:0] inst_dram_start;
  logic [FIELD_W-1:0] inst_dram_bytes;
  logic               inst_zero;

  assign inst_buf_start  = ctrl_instruction[32 +: BW];
  assign inst_beats      = ctrl_instruction[48 +: BW];
  assign inst_dram_start = ctrl_instruction[64 +: FIELD_W];
  assign inst_dram_bytes = ctrl_instruction[80 +: FIELD_W];
  assign inst_zero       = (inst_beats == '0);

  // Instruction bits that carry no meaning for this stage
  logic unused_inst_bits;
  assign unused_inst_bits = ^{ctrl_instruction[31:0],
                              ctrl_instruction[47:32+BW],
                              ctrl_instruction[63:48+BW]};

  // Run bookkeeping
  logic [BW-1:0]    rd_left_q;
  logic [BW-1:0]    rd_addr_q;
  logic             wr_seen_q;
  logic             acc_done_q;
  logic             inflight_q;
  logic             inflight_last_q;

  // Output FIFO storage
  logic [DW-1:0]    fifo_data_q [FIFO_DEPTH];
  logic             fifo_last_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Combinational control
  logic accept_c;
  logic head_valid_c;
  logic pop_c;
  logic space_c;
  logic last_read_c;
  logic last_pop_c;
  logic finish_c;
  logic rd_en_c;
  logic enter_done_c;

  assign accept_c     = (state_q == S_IDLE) && ap_start && !ap_done;
  assign head_valid_c = (count_q != '0);
  assign pop_c        = head_valid_c && data_tready;
  assign last_read_c  = (rd_left_q == BW'(1));
  assign last_pop_c   = pop_c && fifo_last_q[rd_ptr_q];
  // A beat leaving this cycle frees its slot for a read issued now
  assign space_c      = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_c));
  assign finish_c     = (acc_done_q || last_pop_c) && (wr_seen_q || wr_done);

  // State register
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; a zero-length instruction spends one cycle in DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = inst_zero ? S_DRAIN : S_RUN;
      S_RUN:   if (rd_en_c && last_read_c) state_d = S_DRAIN;
      S_DRAIN: if (finish_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: read strobe and DONE-entry marker
  always_comb begin
    rd_en_c      = 1'b0;
    enter_done_c = 1'b0;
    if ((state_q == S_RUN) && (rd_left_q != '0) && space_c) rd_en_c = 1'b1;
    if ((state_d == S_DONE) && (state_q != S_DONE)) enter_done_c = 1'b1;
  end

  assign buf_rd_en   = rd_en_c;
  assign buf_rd_addr = rd_addr_q;

  // ap_done is high for the single cycle spent in DONE, and out of reset
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) ap_done <= 1'b1;
    else            ap_done <= (state_d == S_DONE);
  end

  // Write master setup, latched at accept and held for the whole instruction
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      wr_start <= 1'b0;
      wr_addr  <= '0;
      wr_size  <= '0;
    end else begin
      wr_start <= accept_c && !inst_zero;
      if (accept_c) begin
        wr_addr <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(inst_dram_start);
        wr_size <= C_XFER_SIZE_WIDTH'(inst_dram_bytes);
      end
    end
  end

  // Read address generation and remaining-read counter
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      rd_left_q <= '0;
      rd_addr_q <= '0;
    end else if (accept_c) begin
      rd_left_q <= inst_beats;
      rd_addr_q <= inst_buf_start;
    end else if (rd_en_c) begin
      rd_left_q <= rd_left_q - BW'(1);
      rd_addr_q <= rd_addr_q + BW'(1);
    end
  end

  // Track the read whose data returns next cycle, tagged if it is the last
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_en_c;
      inflight_last_q <= rd_en_c && last_read_c;
    end
  end

  // Completion flags: sticky wr_done and final-beat acceptance
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      wr_seen_q  <= 1'b0;
      acc_done_q <= 1'b0;
    end else if (enter_done_c) begin
      wr_seen_q  <= 1'b0;
      acc_done_q <= 1'b0;
    end else if (accept_c) begin
      wr_seen_q  <= inst_zero;
      acc_done_q <= inst_zero;
    end else begin
      if (wr_done && ((state_q == S_RUN) || (state_q == S_DRAIN))) wr_seen_q <= 1'b1;
      if (last_pop_c) acc_done_q <= 1'b1;
    end
  end

  // Two-entry output FIFO written by returning read data, drained by the stream
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= buf_rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q <= CNT_W'(count_q + CNT_W'(inflight_q) - CNT_W'(pop_c));
    end
  end

  assign data_tvalid = head_valid_c;
  assign data_tdata  = fifo_data_q[rd_ptr_q];
  assign data_tlast  = head_valid_c && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_save_stream.sv
// Scoreboard bench for save_stream: random buffer contents, randomized
// instructions and backpressure, expectations derived from instruction fields.
module tb_save_stream;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned XW = 32;
  localparam int unsigned BW = 11;
  localparam int unsigned IW = 96;
  localparam int unsigned BUF_WORDS = 2048;

  logic          kernel_clk = 1'b0;
  logic          kernel_rst;
  logic          ap_start;
  logic          ap_done;
  logic [AW-1:0] ctrl_addr_offset;
  logic [IW-1:0] ctrl_instruction;
  logic          buf_rd_en;
  logic [BW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data = '0;
  logic          wr_start;
  logic [AW-1:0] wr_addr;
  logic [XW-1:0] wr_size;
  logic          wr_done;
  logic          data_tvalid;
  logic          data_tready = 1'b1;
  logic [DW-1:0] data_tdata;
  logic          data_tlast;

  always #5 kernel_clk = ~kernel_clk;

  save_stream dut (
    .kernel_clk       (kernel_clk),
    .kernel_rst       (kernel_rst),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ctrl_addr_offset (ctrl_addr_offset),
    .ctrl_instruction (ctrl_instruction),
    .buf_rd_en        (buf_rd_en),
    .buf_rd_addr      (buf_rd_addr),
    .buf_rd_data      (buf_rd_data),
    .wr_start         (wr_start),
    .wr_addr          (wr_addr),
    .wr_size          (wr_size),
    .wr_done          (wr_done),
    .data_tvalid      (data_tvalid),
    .data_tready      (data_tready),
    .data_tdata       (data_tdata),
    .data_tlast       (data_tlast)
  );

  // Output buffer model: one-cycle read latency
  logic [DW-1:0] mem [BUF_WORDS];
  always @(posedge kernel_clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

  int cyc = 0;
  always @(posedge kernel_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  beat_t         exp_beats[$];
  int            exp_addrs[$];
  logic [AW-1:0] exp_wr_addr;
  logic [XW-1:0] exp_wr_size;
  bit            wr_pending, done_pending, first_pending, zero_len;
  bit            done_seen, last_seen, stalled;
  logic [DW-1:0] held_data;
  int            start_cyc, acc_last_cyc, wr_cyc, cur_beats;
  int            n_issued, n_accepted;
  int            tready_mode = 0;
  int            phase = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Ready pattern: 0 always ready, 1 the 1,0,0,1 pattern, 2 random
  always @(posedge kernel_clk) begin
    #1;
    phase++;
    case (tready_mode)
      0:       data_tready = 1'b1;
      1:       data_tready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: data_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops expectations as the DUT presents reads, setup, beats, done
  always @(negedge kernel_clk) begin
    if (!kernel_rst) begin
      beat_t b;
      int    exp_done;
      if (buf_rd_en || data_tvalid)
        chk("outstanding_le2", DW'(n_issued - n_accepted <= 2), DW'(1));
      if (buf_rd_en) begin
        if (exp_addrs.size() == 0) chk("rd_unexpected", DW'(buf_rd_addr), DW'(0) - 1);
        else chk("rd_addr", DW'(buf_rd_addr), DW'(exp_addrs.pop_front()));
        n_issued++;
      end
      if (wr_start) begin
        chk("wr_start_expected", DW'(wr_pending), DW'(1));
        chk("wr_start_cycle", DW'(cyc), DW'(start_cyc + 1));
        chk("wr_addr", DW'(wr_addr), DW'(exp_wr_addr));
        chk("wr_size", DW'(wr_size), DW'(exp_wr_size));
        wr_pending = 1'b0;
      end
      if (wr_done) wr_cyc = cyc;
      if (stalled) begin
        chk("tvalid_hold", DW'(data_tvalid), DW'(1));
        chk("tdata_hold", data_tdata, held_data);
      end
      if (data_tvalid) begin
        if (first_pending) begin
          chk("first_tvalid_cycle", DW'(cyc), DW'(start_cyc + 3));
          first_pending = 1'b0;
        end
        if (data_tready) begin
          if (exp_beats.size() == 0) chk("beat_unexpected", data_tdata, '0);
          else begin
            b = exp_beats.pop_front();
            chk("tdata", data_tdata, b.d);
            chk("tlast", DW'(data_tlast), DW'(b.last));
            if (b.last) begin
              acc_last_cyc = cyc;
              last_seen    = 1'b1;
              if (tready_mode == 0)
                chk("last_beat_cycle", DW'(cyc), DW'(start_cyc + 2 + cur_beats));
            end
          end
          n_accepted++;
        end
      end
      stalled   = data_tvalid && !data_tready;
      held_data = data_tdata;
      if (ap_done) begin
        chk("done_expected", DW'(done_pending), DW'(1));
        exp_done = zero_len ? start_cyc + 2
                            : ((acc_last_cyc > wr_cyc) ? acc_last_cyc : wr_cyc) + 1;
        chk("done_cycle", DW'(cyc), DW'(exp_done));
        done_pending = 1'b0;
        done_seen    = 1'b1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ap_done"},  DW'(ap_done), DW'(1));
    chk({tag, "_rd_en"},    DW'(buf_rd_en), DW'(0));
    chk({tag, "_rd_addr"},  DW'(buf_rd_addr), DW'(0));
    chk({tag, "_wr_start"}, DW'(wr_start), DW'(0));
    chk({tag, "_wr_addr"},  DW'(wr_addr), DW'(0));
    chk({tag, "_wr_size"},  DW'(wr_size), DW'(0));
    chk({tag, "_tvalid"},   DW'(data_tvalid), DW'(0));
    chk({tag, "_tlast"},    DW'(data_tlast), DW'(0));
    chk({tag, "_tdata"},    data_tdata, '0);
  endtask

  // Load expectations for one instruction and pulse ap_start
  task automatic arm_and_start(input logic [AW-1:0] offset, input int bstart, input int beats,
                               input int dstart, input int dbytes, input int tmode);
    logic [IW-1:0] inst;
    beat_t         b;
    int            a;
    inst = '0;
    inst[47:32] = 16'(bstart);
    inst[63:48] = 16'(beats);
    inst[79:64] = 16'(dstart);
    inst[95:80] = 16'(dbytes);
    for (int i = 0; i < beats; i++) begin
      a = (bstart + i) % BUF_WORDS;
      exp_addrs.push_back(a);
      b.d    = mem[a];
      b.last = (i == beats - 1);
      exp_beats.push_back(b);
    end
    exp_wr_addr   = offset + AW'(dstart);
    exp_wr_size   = XW'(dbytes);
    wr_pending    = (beats != 0);
    first_pending = (beats != 0);
    zero_len      = (beats == 0);
    done_pending  = 1'b1;
    done_seen     = 1'b0;
    last_seen     = 1'b0;
    cur_beats     = beats;
    acc_last_cyc  = -1;
    wr_cyc        = -1;
    tready_mode   = tmode;
    @(posedge kernel_clk); #1;
    ctrl_instruction = inst;
    ctrl_addr_offset = offset;
    ap_start         = 1'b1;
    start_cyc        = cyc;
    @(posedge kernel_clk); #1;
    ap_start = 1'b0;
  endtask

  // wmode: 0 three cycles after last beat, 1 early, 2 with last beat, 3 never
  task automatic drive_wr_done(input int wmode, input int beats);
    int n;
    case (wmode)
      0: begin
        n = 0;
        while (!last_seen && n < 400) begin @(posedge kernel_clk); n++; end
        #1;
        if (last_seen) begin
          repeat (2) @(posedge kernel_clk);
          #1 wr_done = 1'b1;
          @(posedge kernel_clk); #1 wr_done = 1'b0;
        end
      end
      1: begin
        @(posedge kernel_clk); #1 wr_done = 1'b1;
        @(posedge kernel_clk); #1 wr_done = 1'b0;
      end
      2: begin
        repeat (beats + 1) @(posedge kernel_clk);
        #1 wr_done = 1'b1;
        @(posedge kernel_clk); #1 wr_done = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 600) begin @(posedge kernel_clk); n++; end
    if (!done_seen) chk("done_timeout", DW'(0), DW'(1));
  endtask

  task automatic poke_start();
    repeat (4) @(posedge kernel_clk);
    #1;
    ctrl_instruction = {$urandom, $urandom, $urandom};
    ap_start = 1'b1;
    @(posedge kernel_clk); #1 ap_start = 1'b0;
  endtask

  task automatic run_inst(input logic [AW-1:0] offset, input int bstart, input int beats,
                          input int dstart, input int dbytes, input int wmode,
                          input int tmode, input bit poke);
    arm_and_start(offset, bstart, beats, dstart, dbytes, tmode);
    fork
      drive_wr_done(wmode, beats);
      wait_done();
      if (poke) poke_start();
    join
    chk("beats_left", DW'(exp_beats.size()), DW'(0));
    chk("addrs_left", DW'(exp_addrs.size()), DW'(0));
    chk("wr_start_seen", DW'(wr_pending), DW'(0));
  endtask

  initial begin
    int tm, wm;
    kernel_rst       = 1'b1;
    ap_start         = 1'b0;
    ctrl_instruction = '0;
    ctrl_addr_offset = '0;
    wr_done          = 1'b0;
    n_issued         = 0;
    n_accepted       = 0;
    stalled          = 1'b0;
    for (int i = 0; i < BUF_WORDS; i++)
      for (int k = 0; k < DW / 32; k++) mem[i][k*32 +: 32] = $urandom;
    repeat (2) @(posedge kernel_clk);
    #1 check_reset_outputs("reset");
    @(negedge kernel_clk); #1 kernel_rst = 1'b0;
    repeat (2) @(posedge kernel_clk);

    run_inst(64'h1000, 5, 4, 'h40, 256, 0, 0, 1'b0);
    run_inst(64'h2000, 100, 8, 'h10, 512, 0, 1, 1'b0);
    run_inst(64'h0, 2046, 4, 'h80, 256, 2, 0, 1'b0);
    run_inst(64'h3000, 700, 6, 'h22, 384, 1, 2, 1'b0);
    run_inst(64'h4000, 9, 0, 'h33, 64, 3, 0, 1'b0);
    run_inst(64'h5000, 2040, 12, 'h44, 768, 0, 1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      tm = $urandom_range(0, 2);
      wm = (tm == 0) ? $urandom_range(0, 2) : $urandom_range(0, 1);
      run_inst({$urandom, $urandom}, $urandom_range(0, 2047), $urandom_range(1, 12),
               $urandom_range(0, 65535), $urandom_range(0, 65535), wm, tm, 1'b0);
    end

    // Reset in the middle of a long run
    arm_and_start(64'h6000, 300, 20, 'h55, 1280, 0);
    repeat (6) @(posedge kernel_clk);
    #1 kernel_rst = 1'b1;
    #1 check_reset_outputs("midreset");
    exp_beats.delete();
    exp_addrs.delete();
    wr_pending    = 1'b0;
    done_pending  = 1'b0;
    first_pending = 1'b0;
    stalled       = 1'b0;
    n_issued      = 0;
    n_accepted    = 0;
    repeat (3) @(posedge kernel_clk);
    @(negedge kernel_clk); #1 kernel_rst = 1'b0;
    repeat (2) @(posedge kernel_clk);
    run_inst(64'h7000, 1000, 7, 'h66, 448, 0, 2, 1'b0);

    repeat (3) @(posedge kernel_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
